// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction fetch bridge.
// Holds the instruction bus widths, the zero-word constant, the reset and
// chip-enable levels, and the fetch FSM state encoding.
package inst_fetch_bridge_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD   = '0;
  localparam logic              RST_ENABLE  = 1'b1;
  localparam logic              CHIP_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    IFB_IDLE = 2'd0,
    IFB_REQ  = 2'd1,
    IFB_WAIT = 2'd2
  } ifb_state_e;

endpackage

// File: rtl/ifb_array.sv
// Direct-mapped instruction buffer storage: one valid bit, tag and 32-bit
// word per entry.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   i_clear             invalidate every entry at the next edge
//   i_rd_idx            asynchronous read index
//   o_rd_valid/tag/data entry contents at i_rd_idx
//   i_wr_en/idx/tag/data  synchronous fill port
// Clearing (reset or flush) takes priority over a fill in the same cycle.
module ifb_array
  import inst_fetch_bridge_pkg::*;
#(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned TAG_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [INST_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [INST_W-1:0] i_wr_data
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [INST_W-1:0] r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || i_clear) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/inst_fetch_bridge.sv
// Bridge between the cpu instruction port and a req/ack/rvalid instruction
// bus, with a small direct-mapped instruction buffer in front of the bus.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rom_ce_i, rom_addr_i           fetch request from pc_reg
//   rom_data_o, stallreq_o         instruction to if_id / hold pipeline
//   flush_i                        invalidate the whole buffer
//   bus_req_o, bus_addr_o          bus read request (held until bus_ack_i)
//   bus_ack_i, bus_rvalid_i, bus_rdata_i  bus handshake and read data
// A hit answers in the same cycle; a miss stalls, walks IDLE->REQ->WAIT and
// fills the buffer, after which the retried lookup in IDLE hits.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned ADDR_W = INST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [ADDR_W-1:0] rom_addr_i,
  output logic [INST_W-1:0] rom_data_o,
  output logic              stallreq_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic              bus_ack_i,
  input  logic              bus_rvalid_i,
  input  logic [INST_W-1:0] bus_rdata_i
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  ifb_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_miss_addr, w_miss_addr_nxt;
  logic              r_drop, w_drop_nxt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_rd_valid;
  logic [TAG_W-1:0]  w_rd_tag;
  logic [INST_W-1:0] w_rd_data;
  logic              w_hit;
  logic              w_fill;
  logic              w_unused_lsb;

  assign w_idx        = rom_addr_i[IDX_W+1:2];
  assign w_tag        = rom_addr_i[ADDR_W-1:IDX_W+2];
  assign w_unused_lsb = ^rom_addr_i[1:0];

  // A flush in the lookup cycle forces a miss, since the entry is being
  // invalidated at this very edge.
  assign w_hit = (rom_ce_i == CHIP_ENABLE) && w_rd_valid
                 && (w_rd_tag == w_tag) && !flush_i;

  ifb_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (flush_i),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_fill),
    .i_wr_idx   (r_miss_addr[IDX_W+1:2]),
    .i_wr_tag   (r_miss_addr[ADDR_W-1:IDX_W+2]),
    .i_wr_data  (bus_rdata_i)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state     <= IFB_IDLE;
      r_miss_addr <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_miss_addr <= w_miss_addr_nxt;
      r_drop      <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_miss_addr_nxt = r_miss_addr;
    w_drop_nxt      = r_drop;
    rom_data_o      = ZERO_WORD;
    stallreq_o      = 1'b0;
    bus_req_o       = 1'b0;
    w_fill          = 1'b0;
    unique case (r_state)
      IFB_IDLE: begin
        if (rom_ce_i == CHIP_ENABLE) begin
          if (w_hit) begin
            rom_data_o = w_rd_data;
          end else begin
            stallreq_o      = 1'b1;
            w_miss_addr_nxt = {rom_addr_i[ADDR_W-1:2], 2'b00};
            w_drop_nxt      = 1'b0;
            w_state_nxt     = IFB_REQ;
          end
        end
      end
      IFB_REQ: begin
        stallreq_o = 1'b1;
        bus_req_o  = 1'b1;
        if (bus_ack_i) begin
          w_state_nxt = IFB_WAIT;
        end
      end
      IFB_WAIT: begin
        stallreq_o = 1'b1;
        // A flush while waiting poisons the outstanding fill; the data is
        // still consumed so the bus sees a completed transaction.
        if (flush_i) begin
          w_drop_nxt = 1'b1;
        end
        if (bus_rvalid_i) begin
          w_fill      = !r_drop && !flush_i;
          w_drop_nxt  = 1'b0;
          w_state_nxt = IFB_IDLE;
        end
      end
      default: begin
        w_state_nxt = IFB_IDLE;
      end
    endcase
  end

  assign bus_addr_o = r_miss_addr;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
module tb_inst_fetch_bridge;

  logic        clk;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        flush_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  inst_fetch_bridge #(
    .IDX_W  (3),
    .ADDR_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce_i),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .stallreq_o   (stallreq_o),
    .flush_i      (flush_i),
    .bus_req_o    (bus_req_o),
    .bus_addr_o   (bus_addr_o),
    .bus_ack_i    (bus_ack_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          ackd;
    int          rvd;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int   total = 0;
  int   bad   = 0;
  int   bus_txns = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, req, $time);
    end
  endtask

  task automatic bus_exp(input logic [31:0] a, input logic [31:0] d, input int ackd, input int rvd);
    bus_t b;
    b.addr = a; b.data = d; b.ackd = ackd; b.rvd = rvd;
    bus_q.push_back(b);
  endtask

  // Issue one fetch; expected word and stall length go to the scoreboard.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int st);
    exp_t e;
    bit   done;
    e.addr = a; e.data = d; e.stall = st;
    exp_q.push_back(e);
    rom_addr_i = a;
    rom_ce_i   = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (!stallreq_o) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL fetch_timeout addr=%h actual=stalled required=complete", a);
    end
    @(posedge clk); #1;
    rom_ce_i = 1'b0;
  endtask

  // Monitor: pops an expectation whenever a fetch is satisfied.
  int stall_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      stall_run = 0;
    end else if (!rom_ce_i) begin
      stall_run = 0;
      if (!bus_req_o && !bus_ack_i) begin
        chk("ce0_data", rom_data_o, 32'h0);
      end
    end else if (stallreq_o) begin
      stall_run++;
      chk("stall_data_zero", rom_data_o, 32'h0);
    end else begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_fetch actual=%h required=no_output", rom_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("data@%h", e.addr), rom_data_o, e.data);
        chk($sformatf("stall@%h", e.addr), 32'(stall_run), 32'(e.stall));
      end
      stall_run = 0;
    end
  end

  // Bus responder: ack after ackd extra REQ cycles, rvalid rvd cycles later.
  initial begin
    bus_t cur;
    int   ph;
    int   cnt;
    ph = 0; cnt = 0;
    cur.addr = '0; cur.data = '0; cur.ackd = 0; cur.rvd = 1;
    bus_ack_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus_ack_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      if (rst) begin
        ph = 0;
      end else if (ph == 2) begin
        chk("bus_req_low_in_wait", {31'b0, bus_req_o}, 32'h0);
        cnt++;
        if (cnt >= cur.rvd) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = cur.data;
          ph = 0;
        end
      end else begin
        if (ph == 0 && bus_req_o) begin
          total++;
          if (bus_q.size() == 0) begin
            bad++;
            $display("FAIL bus_unexpected_req actual=%h required=no_request", bus_addr_o);
          end else begin
            cur = bus_q.pop_front();
            bus_txns++;
            chk("bus_addr", bus_addr_o, cur.addr);
            ph = 1; cnt = 0;
          end
        end
        if (ph == 1) begin
          chk("bus_req_held", {31'b0, bus_req_o}, 32'h1);
          chk("bus_addr_stable", bus_addr_o, cur.addr);
          if (cnt >= cur.ackd) begin
            bus_ack_i = 1'b1;
            ph = 2; cnt = 0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit seen;
    rst = 1'b1; rom_ce_i = 1'b0; rom_addr_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_bus_req",  {31'b0, bus_req_o},  32'h0);
    chk("rst_bus_addr", bus_addr_o,          32'h0);
    chk("rst_rom_data", rom_data_o,          32'h0);
    chk("rst_stall",    {31'b0, stallreq_o}, 32'h0);
    @(posedge clk); #1;

    // 1 cold fetch
    bus_exp(32'h0, 32'h3401_1100, 0, 1);
    fetch(32'h0, 32'h3401_1100, 3);

    // 2 refetch hits, neighbours miss once, low address bits ignored
    fetch(32'h0, 32'h3401_1100, 0);
    bus_exp(32'h4, 32'hA000_0004, 0, 1);
    fetch(32'h4, 32'hA000_0004, 3);
    bus_exp(32'h8, 32'hA000_0008, 0, 1);
    fetch(32'h8, 32'hA000_0008, 3);
    fetch(32'h5, 32'hA000_0004, 0);
    fetch(32'hB, 32'hA000_0008, 0);

    // 3 conflict on index 0
    bus_exp(32'h20, 32'hC000_0020, 0, 1);
    fetch(32'h20, 32'hC000_0020, 3);
    bus_exp(32'h0, 32'h3401_1100, 0, 1);
    fetch(32'h0, 32'h3401_1100, 3);

    // 4 slow bus: ack after 4 cycles, rvalid 3 cycles later
    t0 = bus_txns;
    bus_exp(32'h40, 32'h4040_4040, 4, 3);
    fetch(32'h40, 32'h4040_4040, 9);
    chk("single_fill", 32'(bus_txns - t0), 32'h1);
    fetch(32'h40, 32'h4040_4040, 0);

    // 5 flush during WAIT drops the fill; the retry refetches
    bus_exp(32'h64, 32'hDEAD_BEEF, 0, 3);
    bus_exp(32'h64, 32'h1111_2222, 0, 1);
    fork
      fetch(32'h64, 32'h1111_2222, 8);
      begin
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
          @(negedge clk);
          if (bus_req_o) seen = 1'b1;
        end
        @(posedge clk); #1 flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
      end
    join
    bus_exp(32'h4, 32'hA000_0004, 0, 1);
    fetch(32'h4, 32'hA000_0004, 3);

    // 6 reset in the middle of REQ
    bus_exp(32'h100, 32'h0100_0100, 0, 1);
    fetch(32'h100, 32'h0100_0100, 3);
    fetch(32'h100, 32'h0100_0100, 0);
    bus_exp(32'h104, 32'hBAD0_0104, 10, 1);
    rom_addr_i = 32'h104;
    rom_ce_i   = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus_req_o) seen = 1'b1;
    end
    chk("rst6_req_seen", {31'b0, seen}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; rom_ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst6_bus_req",  {31'b0, bus_req_o},  32'h0);
    chk("rst6_stall",    {31'b0, stallreq_o}, 32'h0);
    chk("rst6_bus_addr", bus_addr_o,          32'h0);
    @(posedge clk); #1;
    bus_exp(32'h100, 32'h0200_0200, 0, 1);
    fetch(32'h100, 32'h0200_0200, 3);

    repeat (4) @(posedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
